// File: rtl/i2c_slave_shifter.sv
// rtl/i2c_slave_shifter.sv - I2C slave bit-level datapath: pin sync, START/STOP detect, address match, byte shift
module i2c_slave_shifter #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       mack_q, mack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev, addr_hit;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_dly_q;
  assign scl_fall = ~scl_s & scl_dly_q;
  assign start_ev = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_ev  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign addr_hit = (shreg_q[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_dly_q   <= 1'b1;
      sda_dly_q   <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      mack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q   <= scl_s;
      sda_dly_q   <= sda_s;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      mack_q      <= mack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Bus conditions outrank SCL edges seen in the same clock.
  always_comb begin
    state_d = state_q;
    if (stop_ev) begin
      state_d = S_IDLE;
    end else if (start_ev) begin
      state_d = S_ADDR;
    end else if (scl_rise) begin
      if (state_q == S_RD_ACK && sda_s) state_d = S_IGNORE;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR:     if (bit_cnt_q == 4'd8) state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: state_d = rw_q ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (bit_cnt_q == 4'd8) state_d = S_WR_ACK;
        S_WR_ACK:   state_d = S_WR_DATA;
        S_RD_DATA:  if (bit_cnt_q == 4'd8) state_d = S_RD_ACK;
        S_RD_ACK:   if (mack_q) state_d = S_RD_DATA;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    mack_d      = mack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    rw_d        = rw_q;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    if (stop_ev) begin
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
      bit_cnt_d  = 4'd0;
      mack_d     = 1'b0;
    end else if (start_ev) begin
      busy_d      = 1'b1;
      start_det_d = 1'b1;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 4'd0;
      mack_d      = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_WR_DATA: if (bit_cnt_q != 4'd8) begin
          shreg_d   = {shreg_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        S_RD_DATA: if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
        S_RD_ACK: if (!sda_s) begin
          tx_req_d = 1'b1;
          mack_d   = 1'b1;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: if (bit_cnt_q == 4'd8 && addr_hit) begin
          rw_d     = shreg_q[0];
          sda_oe_d = 1'b1;
          tx_req_d = shreg_q[0];
        end
        S_ADDR_ACK: begin
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
          if (rw_q) begin
            shreg_d  = tx_data;
            sda_oe_d = ~tx_data[7];
          end
        end
        S_WR_DATA: if (bit_cnt_q == 4'd8) begin
          rx_data_d  = shreg_q;
          rx_valid_d = 1'b1;
          sda_oe_d   = rx_ready;
        end
        S_WR_ACK: begin
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
        end
        S_RD_DATA: begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
        S_RD_ACK: if (mack_q) begin
          shreg_d   = tx_data;
          sda_oe_d  = ~tx_data[7];
          bit_cnt_d = 4'd0;
          mack_d    = 1'b0;
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign rw        = rw_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: doc/i2c_slave_shifter.md
Name: i2c_slave_shifter

Overview:
- Bit-level datapath of the I2C slave, running alongside the I2C protocol FSM.
- Oversamples raw SCL/SDA on the system clock, detects START and STOP, and shifts address and data bytes MSB-first.
- Matches the 7-bit slave address, drives ACK and read data through an open-drain enable, and exchanges bytes with the register/FIFO layer via strobes.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit address this slave answers to.
SYNC_STAGES, 2, synchronizer flops on scl/sda (min 2).

Ports:
clk  input  1  system clock; must be ≥8x the SCL rate.
rst  input  1  reset, synchronous and active-low (rst=0 resets on clk rising edge).
scl_in  input  1  raw SCL pin value, asynchronous.
sda_in  input  1  raw SDA pin value, asynchronous.
sda_oe  output  1  1 = pull SDA low; 0 = release.
rx_data  output  8  last written byte.
rx_valid  output  1  one-clk strobe; rx_data is valid.
rx_ready  input  1  1 = consumer can accept a byte; sampled at write-byte ACK time.
tx_data  input  8  byte to send on a read.
tx_req  output  1  one-clk strobe requesting the next tx_data.
rw  output  1  R/W bit latched from the address byte.
busy  output  1  1 between START and STOP.
start_det  output  1  one-clk pulse on START or repeated START.
stop_det  output  1  one-clk pulse on STOP.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, start_det=0, stop_det=0, state=IDLE.
- Synchronizers and delayed copies of SCL/SDA reset to 1 (the bus idle level).
- Event detection, evaluated on the synchronized signals plus one delay register:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Latency from pin change to pulse is SYNC_STAGES+1 clks.
- Bit counter: 0..8, cleared on START and at the end of each ACK slot.
- SDA is sampled on scl_rise into an 8-bit shift register, MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
  - ADDR_ACK
  - WR_DATA
  - WR_ACK
  - RD_DATA
  - RD_ACK
  - IGNORE
- Transitions:
  - START, from any state → ADDR, with busy=1 and start_det pulse. A repeated START mid-byte discards the partial byte.
  - STOP, from any state → IDLE, with busy=0, sda_oe=0 and stop_det pulse.
  - ADDR, at the scl_fall after bit 8:
    - If shreg[7:1]==SLAVE_ADDR: latch rw=shreg[0], go to ADDR_ACK, set sda_oe=1.
    - If rw=1, also pulse tx_req in the same clk.
    - On mismatch: go to IGNORE, sda_oe stays 0.
  - ADDR_ACK, at the next scl_fall: set sda_oe=0, then go to WR_DATA (rw=0) or RD_DATA (rw=1).
  - RD_DATA: on entry, load tx_data into the shift register at that same scl_fall and set sda_oe = ~tx_data[7].
  - WR_DATA, at the scl_fall after bit 8:
    - rx_data ← shreg, rx_valid pulses 1 clk, go to WR_ACK.
    - sda_oe = rx_ready (ACK if ready, NACK if not).
    - rx_valid fires regardless of rx_ready.
  - WR_ACK, at the next scl_fall: set sda_oe=0, go to WR_DATA.
  - RD_DATA:
    - On each scl_fall, shift and set sda_oe = ~next bit.
    - At the scl_fall after bit 8: set sda_oe=0 (release for master ACK), go to RD_ACK.
  - RD_ACK, sample SDA at scl_rise:
    - 0 (ACK): pulse tx_req, and at the next scl_fall load tx_data and go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: sda_oe=0; leave only on START or STOP.
- tx_data must be stable from the tx_req pulse until the following scl_fall.
- Simultaneous events:
  - STOP/START take priority over scl edges in the same clk.
  - If reset and STOP coincide, reset wins and stop_det is not pulsed.
- Reset mid-transfer releases SDA in the same clk edge, and any partial byte is dropped.

Test Plan:
- Write: START, address 0x84 (0x42+W), data 0xA5, 0x3C, STOP, rx_ready=1 → ACK (sda_oe=1) in all 3 ACK slots; rx_valid pulses twice with rx_data 0xA5 then 0x3C; stop_det pulse; busy 1→0.
- Read: START, address 0x85, tx_data=0x5A, master ACK, then tx_data=0xC3, master NACK, STOP → 2 tx_req pulses; SDA reads back 0x5A then 0xC3; sda_oe=0 in both master-ACK slots; state returns to IDLE.
- Address mismatch: address 0x86 then 2 bytes → sda_oe never asserts; no rx_valid; busy=1 until STOP.
- Not ready: write 0x11 with rx_ready=0 → rx_valid pulses with rx_data=0x11; SDA released (NACK) in that ACK slot.
- Repeated START: write address 0x84, 3 data bits, then START, address 0x85 → partial byte dropped, no rx_valid; second start_det pulse; rw=1; tx_req pulse.
- Reset mid-read: assert rst=0 while sda_oe=1 during RD_DATA → next clk sda_oe=0, busy=0, state IDLE; next transaction after release works normally.
